// File: rtl/tmm_pkg.sv
// Shared definitions for the ternary matrix-multiply array driver.
// Holds the weight code points, the on-pin encodings, the driver FSM states
// and the default readout length.
package tmm_pkg;

  localparam int unsigned DEF_N_RESULTS = 16;
  localparam int unsigned SLOTS         = 4;

  // Host-side two's-complement weight codes
  localparam logic [1:0] W_ZERO    = 2'b00;
  localparam logic [1:0] W_POS     = 2'b01;
  localparam logic [1:0] W_ILLEGAL = 2'b10;
  localparam logic [1:0] W_NEG     = 2'b11;

  // Encodings presented on the array's weight pins
  localparam logic [1:0] ENC_ZERO = 2'b00;
  localparam logic [1:0] ENC_POS  = 2'b01;
  localparam logic [1:0] ENC_NEG  = 2'b11;

  typedef enum logic [1:0] {
    STREAM  = 2'd0,
    PULSE   = 2'd1,
    COLLECT = 2'd2
  } state_t;

  // Map one host weight slot to its pin encoding; the illegal code becomes zero
  function automatic logic [1:0] enc_slot(input logic [1:0] w);
    case (w)
      W_POS:   enc_slot = ENC_POS;
      W_NEG:   enc_slot = ENC_NEG;
      default: enc_slot = ENC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/tmm_result_collector.sv
// Result collector: counts edges after the enable pulse, samples res_in inside
// the readout window and emits the indexed result stream.
// Ports: clk, rst_n (sync, active-low); start (edge before pulse end);
//        res_in (array pins); done_c (comb, final sample edge);
//        res_valid/res_data/res_index/res_last (registered result stream).
module tmm_result_collector
  import tmm_pkg::*;
#(
  parameter int unsigned N_RESULTS = DEF_N_RESULTS,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   res_in,
  output logic                         done_c,
  output logic                         res_valid,
  output logic [7:0]                   res_data,
  output logic [$clog2(N_RESULTS)-1:0] res_index,
  output logic                         res_last
);

  localparam int unsigned IDX_W   = $clog2(N_RESULTS);
  localparam int unsigned END_CNT = RD_LAT + N_RESULTS - 1;
  localparam int unsigned CNT_W   = $clog2(END_CNT + 1);

  logic             active;
  logic [CNT_W-1:0] cnt;     // edge offset from the end of the pulse
  logic             sample_c;

  // cnt holds the offset of the upcoming edge while active
  always_comb begin
    sample_c = active && (cnt >= CNT_W'(RD_LAT));
    done_c   = active && (cnt == CNT_W'(END_CNT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
      res_last  <= 1'b0;
    end else begin
      res_valid <= sample_c;
      res_last  <= done_c;
      if (sample_c) begin
        res_data  <= res_in;
        res_index <= IDX_W'(cnt - CNT_W'(RD_LAT));
      end
      if (start) begin
        active <= 1'b1;
        cnt    <= '0;
      end else if (active) begin
        cnt <= cnt + CNT_W'(1);
        if (done_c) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ternary_mm_driver.sv
// Host-to-array driver for a ternary matrix-multiply tile.
// Streams encoded weight/activation beats onto the array pins, issues a
// one-cycle low enable to start readout, then collects N_RESULTS bytes.
// Ports: clk, rst_n (sync, active-low); in_* host beat handshake;
//        ui_o/uio_o/ena_o array drive pins; res_in array result pins;
//        res_* result stream; slice_o parity mirror; err_illegal sticky flag.
module ternary_mm_driver
  import tmm_pkg::*;
#(
  parameter int unsigned N_RESULTS = DEF_N_RESULTS,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_weights,
  input  logic [7:0]                   in_act,
  input  logic                         in_last,
  output logic [7:0]                   ui_o,
  output logic [7:0]                   uio_o,
  output logic                         ena_o,
  input  logic [7:0]                   res_in,
  output logic                         res_valid,
  output logic [7:0]                   res_data,
  output logic [$clog2(N_RESULTS)-1:0] res_index,
  output logic                         res_last,
  output logic                         slice_o,
  output logic                         err_illegal
);

  state_t     state, state_nx;
  logic       in_ready_nx, ena_nx, err_nx, slice_nx;
  logic [7:0] ui_nx, uio_nx, enc_c;
  logic       illegal_c, accept_c, start_c, done_c;

  // Per-slot weight encoding and illegal-code detection
  always_comb begin
    enc_c     = '0;
    illegal_c = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      enc_c[2*k +: 2] = enc_slot(in_weights[2*k +: 2]);
      if (in_weights[2*k +: 2] == W_ILLEGAL) illegal_c = 1'b1;
    end
  end

  // Next state and next pin values; bubble unless a beat or pulse is due
  always_comb begin
    state_nx = state;
    ui_nx    = '0;
    uio_nx   = '0;
    ena_nx   = 1'b1;
    err_nx   = err_illegal;
    start_c  = 1'b0;
    slice_nx = ~slice_o;
    accept_c = in_valid && in_ready;
    case (state)
      STREAM: begin
        if (accept_c) begin
          ui_nx  = enc_c;
          uio_nx = in_act;
          err_nx = err_illegal | illegal_c;
          if (in_last) state_nx = PULSE;
        end
      end
      PULSE: begin
        // Last beat is on the pins now; the low enable follows it directly
        ena_nx   = 1'b0;
        start_c  = 1'b1;
        state_nx = COLLECT;
      end
      COLLECT: begin
        if (done_c) state_nx = STREAM;
      end
      default: state_nx = STREAM;
    endcase
    in_ready_nx = (state_nx == STREAM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= STREAM;
      in_ready    <= 1'b0;
      ui_o        <= '0;
      uio_o       <= '0;
      ena_o       <= 1'b1;
      slice_o     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready    <= in_ready_nx;
      ui_o        <= ui_nx;
      uio_o       <= uio_nx;
      ena_o       <= ena_nx;
      slice_o     <= slice_nx;
      err_illegal <= err_nx;
    end
  end

  tmm_result_collector #(
    .N_RESULTS (N_RESULTS),
    .RD_LAT    (RD_LAT)
  ) u_collector (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .res_in    (res_in),
    .done_c    (done_c),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_index (res_index),
    .res_last  (res_last)
  );

endmodule
